// File: rtl/rifl_rx_remote_monitor.sv
// rifl_rx_remote_monitor
// RX-side tracker of the remote end's flow-control requests. It watches runs of
// identical PAUSE / RETRANS / resume (DATA or IDLE) frames, drives the remote
// pause/retransmit request flags and keeps saturating event statistics.
module rifl_rx_remote_monitor #(
  parameter int FRAME_WIDTH    = 128,
  parameter int PAUSE_THRESH   = 8,
  parameter int RETRANS_THRESH = 8,
  parameter int RESUME_THRESH  = 16,
  parameter int STAT_WIDTH     = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [FRAME_WIDTH-1:0] data_in,
  input  logic                   rx_up,
  input  logic                   payload_valid,
  input  logic                   stat_clr,
  output logic                   remote_pause_req,
  output logic                   remote_retrans_req,
  output logic                   retrans_pulse,
  output logic [STAT_WIDTH-1:0]  pause_events,
  output logic [STAT_WIDTH-1:0]  retrans_events,
  output logic [STAT_WIDTH-1:0]  unknown_frames
);

  localparam logic [3:0]  HDR_CONTROL  = 4'b1010;
  localparam logic [3:0]  HDR_DATA     = 4'b0101;
  localparam logic [15:0] CODE_IDLE    = 16'h9D91;
  localparam logic [15:0] CODE_PAUSE   = 16'hD919;
  localparam logic [15:0] CODE_RETRANS = 16'h919D;

  localparam int PW = $clog2(PAUSE_THRESH + 1);
  localparam int TW = $clog2(RETRANS_THRESH + 1);
  localparam int SW = $clog2(RESUME_THRESH + 1);

  // Encoding is {retrans, pause} so each output is a single state bit.
  typedef enum logic [1:0] {
    ST_RUN             = 2'b00,
    ST_PAUSED          = 2'b01,
    ST_RETRANS         = 2'b10,
    ST_RETRANS_PAUSED  = 2'b11
  } state_t;

  logic [3:0]    hdr_q;
  logic [15:0]   code_q;
  logic          is_ctrl, is_data;
  logic          is_pause, is_retrans, is_resume, is_unknown;
  logic [PW-1:0] pause_cnt;
  logic [TW-1:0] retrans_cnt;
  logic [SW-1:0] resume_cnt;
  logic          pause_hit, retrans_hit, resume_hit;
  logic          rx_up_q;
  state_t        state_q, state_d;
  logic          pause_next, retrans_next;
  logic          pause_rise, retrans_rise;

  // Stage 1: capture header and control code of every frame.
  // NOTE: pure datapath register with no reset or enable; classification is
  // qualified by rx_up, so its post-reset contents never reach state.
  always_ff @(posedge clk) begin
    hdr_q  <= data_in[FRAME_WIDTH-1 -: 4];
    code_q <= data_in[FRAME_WIDTH-7 -: 16];
  end

  // Frame classification from the stage-1 fields; the four classes are exclusive.
  always_comb begin
    is_ctrl    = (hdr_q == HDR_CONTROL);
    is_data    = (hdr_q == HDR_DATA);
    is_pause   = is_ctrl && (code_q == CODE_PAUSE);
    is_retrans = is_ctrl && (code_q == CODE_RETRANS);
    is_resume  = is_data || (is_ctrl && (code_q == CODE_IDLE));
    is_unknown = !(is_pause || is_retrans || is_resume);
  end

  // Run-length counters: restart on a class change or link down, saturate at threshold.
  always_ff @(posedge clk) begin
    if (rst || !rx_up) begin
      pause_cnt   <= '0;
      retrans_cnt <= '0;
      resume_cnt  <= '0;
    end else begin
      if (!is_pause)                            pause_cnt   <= '0;
      else if (pause_cnt != PW'(PAUSE_THRESH))  pause_cnt   <= pause_cnt + PW'(1);
      if (!is_retrans)                              retrans_cnt <= '0;
      else if (retrans_cnt != TW'(RETRANS_THRESH))  retrans_cnt <= retrans_cnt + TW'(1);
      if (!is_resume)                           resume_cnt  <= '0;
      else if (resume_cnt != SW'(RESUME_THRESH)) resume_cnt <= resume_cnt + SW'(1);
    end
  end

  assign pause_hit   = (pause_cnt   == PW'(PAUSE_THRESH));
  assign retrans_hit = (retrans_cnt == TW'(RETRANS_THRESH));
  assign resume_hit  = (resume_cnt  == SW'(RESUME_THRESH));

  // Link-state history for detecting rx_up falling; reset low so a link that
  // is down out of reset is not seen as a drop.
  always_ff @(posedge clk) begin
    if (rst) rx_up_q <= 1'b0;
    else     rx_up_q <= rx_up;
  end

  // Request state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_PAUSED;
    else     state_q <= state_d;
  end

  // Next request state: per-bit priority while the link is up, forced pause on link drop.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    pause_next   = state_q[0];
    retrans_next = state_q[1];
    if (rx_up) begin
      if (pause_hit)                                     pause_next = 1'b1;
      else if (payload_valid || resume_hit || retrans_hit) pause_next = 1'b0;
      if (resume_hit)       retrans_next = 1'b0;
      else if (retrans_hit) retrans_next = 1'b1;
    end else if (rx_up_q) begin
      pause_next = 1'b1;
    end
    state_d      = state_t'({retrans_next, pause_next});
    pause_rise   = pause_next & ~state_q[0];
    retrans_rise = retrans_next & ~state_q[1];
  end

  assign remote_pause_req   = state_q[0];
  assign remote_retrans_req = state_q[1];

  // Strobe for the cycle in which remote_retrans_req first reads high.
  always_ff @(posedge clk) begin
    if (rst) retrans_pulse <= 1'b0;
    else     retrans_pulse <= retrans_rise;
  end

  // Saturating statistics; a clear wins over an event in the same cycle.
  always_ff @(posedge clk) begin
    if (rst || stat_clr) begin
      pause_events   <= '0;
      retrans_events <= '0;
      unknown_frames <= '0;
    end else begin
      if (pause_rise && (pause_events != '1))
        pause_events <= pause_events + STAT_WIDTH'(1);
      if (retrans_rise && (retrans_events != '1))
        retrans_events <= retrans_events + STAT_WIDTH'(1);
      if (rx_up && is_unknown && (unknown_frames != '1))
        unknown_frames <= unknown_frames + STAT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_rifl_rx_remote_monitor.sv
// Scoreboard bench for rifl_rx_remote_monitor: the stimulus thread queues the
// expected value of one output at a given clock edge; a monitor pops and
// compares on the falling edge after that clock edge.
module tb_rifl_rx_remote_monitor;

  localparam int FW = 128;

  typedef enum int {S_PAUSE, S_RETRANS, S_PULSE, S_PE, S_RE, S_UF, S_PAUSE2, S_PE2} sig_e;
  typedef struct {
    int    due;
    sig_e  sig;
    int    val;
    string name;
  } exp_t;

  logic          clk, rst;
  logic [FW-1:0] data_in, data2;
  logic          rx_up, payload_valid, stat_clr;
  logic          rx_up2, pv2, stat_clr2;
  logic          pause, retrans, pulse;
  logic [15:0]   pe, re, uf;
  logic          pause2, retrans2, pulse2;
  logic [1:0]    pe_2, re_2, uf_2;

  int   edge_cnt = 0;
  int   checks   = 0;
  int   errors   = 0;
  exp_t sb[$];

  rifl_rx_remote_monitor dut (
    .clk(clk), .rst(rst), .data_in(data_in), .rx_up(rx_up),
    .payload_valid(payload_valid), .stat_clr(stat_clr),
    .remote_pause_req(pause), .remote_retrans_req(retrans), .retrans_pulse(pulse),
    .pause_events(pe), .retrans_events(re), .unknown_frames(uf)
  );

  rifl_rx_remote_monitor #(.STAT_WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .data_in(data2), .rx_up(rx_up2),
    .payload_valid(pv2), .stat_clr(stat_clr2),
    .remote_pause_req(pause2), .remote_retrans_req(retrans2), .retrans_pulse(pulse2),
    .pause_events(pe_2), .retrans_events(re_2), .unknown_frames(uf_2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  function automatic logic [FW-1:0] mk(input logic [3:0] hdr, input logic [15:0] code);
    logic [FW-1:0] f;
    f = '0;
    f[FW-1 -: 4]  = hdr;
    f[FW-7 -: 16] = code;
    return f;
  endfunction

  logic [FW-1:0] idle_f, pause_f, retr_f, data_f, bad_f;

  function automatic int read_sig(input sig_e s);
    case (s)
      S_PAUSE:   return int'(pause);
      S_RETRANS: return int'(retrans);
      S_PULSE:   return int'(pulse);
      S_PE:      return int'(pe);
      S_RE:      return int'(re);
      S_UF:      return int'(uf);
      S_PAUSE2:  return int'(pause2);
      default:   return int'(pe_2);
    endcase
  endfunction

  // Monitor: compare every queued expectation that has come due.
  always @(negedge clk) begin
    exp_t e;
    int   act;
    while (sb.size() > 0 && sb[0].due <= edge_cnt) begin
      e   = sb.pop_front();
      act = read_sig(e.sig);
      checks++;
      if (e.due != edge_cnt || act != e.val) begin
        errors++;
        $display("FAIL %s: got %0d expected %0d (edge %0d, due %0d)",
                 e.name, act, e.val, edge_cnt, e.due);
      end
    end
  end

  // Queue an expectation, kept ordered by due edge.
  task automatic expect_at(input sig_e s, input int v, input int due, input string nm);
    exp_t e;
    int   i;
    e.due = due; e.sig = s; e.val = v; e.name = nm;
    i = 0;
    while (i < sb.size() && sb[i].due <= due) i++;
    sb.insert(i, e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Apply frames to the main DUT; k returns the edge that sampled the last one.
  task automatic send_n(input logic [FW-1:0] f, input int n, output int k);
    for (int i = 0; i < n; i++) begin
      data_in = f;
      tick();
    end
    k = edge_cnt;
  endtask

  initial begin
    int k, ki, kd;
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int k, ki, kd;
    idle_f  = mk(4'b1010, 16'h9D91);
    pause_f = mk(4'b1010, 16'hD919);
    retr_f  = mk(4'b1010, 16'h919D);
    data_f  = mk(4'b0101, 16'h1234);
    bad_f   = mk(4'b0000, 16'h0000);

    // 1: reset
    rst = 1'b1; rx_up = 1'b0; payload_valid = 1'b0; stat_clr = 1'b0;
    data_in = pause_f; data2 = idle_f; rx_up2 = 1'b0; pv2 = 1'b0; stat_clr2 = 1'b0;
    repeat (3) tick();
    expect_at(S_PAUSE, 1, edge_cnt, "rst_pause");
    expect_at(S_RETRANS, 0, edge_cnt, "rst_retrans");
    expect_at(S_PULSE, 0, edge_cnt, "rst_pulse");
    expect_at(S_PE, 0, edge_cnt, "rst_pause_events");
    expect_at(S_RE, 0, edge_cnt, "rst_retrans_events");
    expect_at(S_UF, 0, edge_cnt, "rst_unknown");
    expect_at(S_PAUSE2, 1, edge_cnt, "rst_pause_w2");
    expect_at(S_PE2, 0, edge_cnt, "rst_pause_events_w2");
    rst = 1'b0;
    rx_up = 1'b1;

    // 2: 15 IDLE then a bad header leaves pause set; 16 IDLE clears it
    send_n(idle_f, 15, k);
    send_n(bad_f, 1, k);
    expect_at(S_UF, 0, k, "unknown_before");
    expect_at(S_PAUSE, 1, k + 2, "idle15_pause_held");
    expect_at(S_UF, 1, k + 2, "unknown_after_bad");
    send_n(idle_f, 16, k);
    expect_at(S_PAUSE, 1, k + 1, "idle16_pause_late");
    expect_at(S_PAUSE, 0, k + 2, "idle16_pause_clr");

    // 3: 7 RETRANS is not enough; 8 RETRANS asserts retrans
    send_n(retr_f, 7, k);
    send_n(idle_f, 1, ki);
    expect_at(S_RETRANS, 0, ki + 1, "retrans7_a");
    expect_at(S_RETRANS, 0, ki + 2, "retrans7_b");
    send_n(retr_f, 8, k);
    expect_at(S_RETRANS, 0, k + 1, "retrans8_early");
    expect_at(S_PULSE, 0, k + 1, "pulse_early");
    expect_at(S_RETRANS, 1, k + 2, "retrans8_set");
    expect_at(S_PULSE, 1, k + 2, "pulse_high");
    expect_at(S_PAUSE, 0, k + 2, "retrans8_pause");
    expect_at(S_RE, 1, k + 2, "retrans_events_1");
    expect_at(S_PULSE, 0, k + 3, "pulse_one_cycle");
    send_n(retr_f, 2, k);

    // 4: 8 PAUSE while retransmitting -> 11; 16 DATA -> 00
    send_n(pause_f, 8, k);
    expect_at(S_PAUSE, 0, k + 1, "pause8_early");
    expect_at(S_PAUSE, 1, k + 2, "pause8_set");
    expect_at(S_RETRANS, 1, k + 2, "pause8_retrans_held");
    expect_at(S_PE, 1, k + 2, "pause_events_1");
    send_n(data_f, 16, kd);
    expect_at(S_PAUSE, 1, kd + 1, "data16_pause_late");
    expect_at(S_RETRANS, 1, kd + 1, "data16_retrans_late");
    expect_at(S_PAUSE, 0, kd + 2, "data16_pause_clr");
    expect_at(S_RETRANS, 0, kd + 2, "data16_retrans_clr");
    expect_at(S_RE, 1, kd + 2, "retrans_events_held");

    // 5: link drop after 5 PAUSE forces pause; a short run after relink does not hit
    send_n(pause_f, 5, k);
    expect_at(S_PAUSE, 0, k, "run_before_drop");
    rx_up = 1'b0;
    send_n(bad_f, 1, k);
    expect_at(S_PAUSE, 1, k, "drop_pause_forced");
    expect_at(S_RETRANS, 0, k, "drop_retrans_held");
    expect_at(S_PE, 2, k, "pause_events_drop");
    send_n(bad_f, 1, k);
    send_n(pause_f, 1, k);
    rx_up = 1'b1;
    send_n(pause_f, 3, k);
    expect_at(S_PAUSE, 1, k + 2, "relink_pause_held");
    expect_at(S_PE, 2, k + 2, "relink_no_new_event");
    expect_at(S_UF, 1, k + 2, "unknown_ignored_down");
    send_n(idle_f, 2, k);
    payload_valid = 1'b1;
    send_n(idle_f, 1, k);
    payload_valid = 1'b0;
    expect_at(S_PAUSE, 0, k, "payload_valid_clr");
    expect_at(S_PE, 2, k, "payload_valid_no_event");

    // 6: 2-bit statistics saturate; clear beats a same-cycle event
    for (int r = 1; r <= 6; r++) begin
      rx_up2 = 1'b1; pv2 = 1'b1;
      tick();
      if (r == 1) expect_at(S_PAUSE2, 0, edge_cnt, "w2_pause_clr");
      rx_up2 = 1'b0; pv2 = 1'b0;
      if (r == 6) stat_clr2 = 1'b1;
      tick();
      if (r == 3) expect_at(S_PE2, 3, edge_cnt, "w2_events_3");
      if (r == 5) expect_at(S_PE2, 3, edge_cnt, "w2_events_sat");
      if (r == 6) begin
        expect_at(S_PE2, 0, edge_cnt, "w2_clr_beats_event");
        expect_at(S_PAUSE2, 1, edge_cnt, "w2_pause_forced");
      end
    end
    stat_clr2 = 1'b0;
    tick();
    expect_at(S_PE2, 0, edge_cnt, "w2_after_clr");

    repeat (4) tick();
    if (sb.size() != 0) begin
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
      errors += sb.size();
      checks += sb.size();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
